// File: rtl/core_exec_ctrl.sv
// Execution controller for the RV32I core: reset sequencing, run/step/halt gating and M-stage store tracking.
// Optional watchdog enabled with `define CORE_CTRL_WDT_EN.
module core_exec_ctrl #(
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned STEP_CYCLES = 1,
  parameter logic [31:0] DONE_ADDR   = 32'h0000_0064,
  parameter int unsigned WDT_CYCLES  = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic        mem_write_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  output logic        core_rst,
  output logic        core_en,
  output logic [2:0]  state,
  output logic [15:0] store_cnt,
  output logic [31:0] last_addr,
  output logic [31:0] last_data,
  output logic        done
);

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_HALTED     = 3'd1,
    S_RUN        = 3'd2,
    S_STEP       = 3'd3,
    S_DONE       = 3'd4,
    S_TIMEOUT    = 3'd5
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);
  localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]  step_cnt_q, step_cnt_d;
  logic [15:0] store_cnt_q, store_cnt_d;
  logic [31:0] last_addr_q, last_addr_d;
  logic [31:0] last_data_q, last_data_d;
  logic        run_prev_q, step_prev_q, halt_prev_q;
  logic        core_rst_q, core_en_q, done_q;
  logic        run_edge, step_edge, halt_edge;
  logic        qual_store, done_store;

  assign run_edge   = run_req & ~run_prev_q;
  assign step_edge  = step_req & ~step_prev_q;
  assign halt_edge  = halt_req & ~halt_prev_q;
  assign qual_store = mem_write_m & core_en_q;
  assign done_store = qual_store && (alu_result_m == DONE_ADDR);

`ifdef CORE_CTRL_WDT_EN
  localparam logic [31:0] WDT_LIMIT = 32'(WDT_CYCLES);
  logic [31:0] wdt_q, wdt_d;

  // Counts only while running; leaving RUN or any store restarts it.
  assign wdt_d = (state_q == S_RUN && !qual_store) ? wdt_q + 32'd1 : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) wdt_q <= 32'd0;
    else     wdt_q <= wdt_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    step_cnt_d = step_cnt_q;
    case (state_q)
      S_RESET_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = S_HALTED;
        else hold_cnt_d = hold_cnt_q + 8'd1;
      end
      S_HALTED: begin
        if (!halt_edge) begin
          if (step_edge) begin
            state_d    = S_STEP;
            step_cnt_d = STEP_LOAD;
          end else if (run_edge) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (halt_edge) state_d = S_HALTED;
        else if (done_store) state_d = S_DONE;
`ifdef CORE_CTRL_WDT_EN
        else if (wdt_q >= WDT_LIMIT) state_d = S_TIMEOUT;
`endif
      end
      S_STEP: begin
        if (halt_edge) state_d = S_HALTED;
        else if (done_store) state_d = S_DONE;
        else if (step_cnt_q == 8'd1) state_d = S_HALTED;
        else step_cnt_d = step_cnt_q - 8'd1;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    store_cnt_d = store_cnt_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    if (qual_store) begin
      last_addr_d = alu_result_m;
      last_data_d = write_data_m;
      if (store_cnt_q != 16'hFFFF) store_cnt_d = store_cnt_q + 16'd1;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET_HOLD;
      hold_cnt_q  <= 8'd0;
      step_cnt_q  <= 8'd0;
      store_cnt_q <= 16'd0;
      last_addr_q <= 32'd0;
      last_data_q <= 32'd0;
      run_prev_q  <= 1'b1;
      step_prev_q <= 1'b1;
      halt_prev_q <= 1'b1;
      core_rst_q  <= 1'b1;
      core_en_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      step_cnt_q  <= step_cnt_d;
      store_cnt_q <= store_cnt_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      run_prev_q  <= run_req;
      step_prev_q <= step_req;
      halt_prev_q <= halt_req;
      core_rst_q  <= (state_d == S_RESET_HOLD);
      core_en_q   <= (state_d == S_RUN) || (state_d == S_STEP);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign state     = state_q;
  assign core_rst  = core_rst_q;
  assign core_en   = core_en_q;
  assign done      = done_q;
  assign store_cnt = store_cnt_q;
  assign last_addr = last_addr_q;
  assign last_data = last_data_q;

endmodule

// File: tb/tb_core_exec_ctrl.sv
// Self-checking bench for core_exec_ctrl: directed test-plan steps plus randomized traffic against a behavioural model.
module tb_core_exec_ctrl;

  localparam int RST_HOLD    = 16;
  localparam int STEP_CYCLES = 3;
  localparam logic [31:0] DONE_ADDR = 32'h0000_0064;
  localparam int WDT_CYCLES  = 100;

  logic        clk = 1'b0;
  logic        rst, run_req, step_req, halt_req, mem_write_m;
  logic [31:0] alu_result_m, write_data_m;
  logic        core_rst, core_en, done;
  logic [2:0]  state;
  logic [15:0] store_cnt;
  logic [31:0] last_addr, last_data;

  int total = 0;
  int bad   = 0;

  // model state
  int          m_state, m_hold, m_steps, m_cnt;
  longint      m_wdt;
  logic [31:0] m_addr, m_data;
  bit          mp_run, mp_step, mp_halt;

  core_exec_ctrl #(
    .RST_HOLD(RST_HOLD), .STEP_CYCLES(STEP_CYCLES),
    .DONE_ADDR(DONE_ADDR), .WDT_CYCLES(WDT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .mem_write_m(mem_write_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .core_rst(core_rst), .core_en(core_en), .state(state), .store_cnt(store_cnt),
    .last_addr(last_addr), .last_data(last_data), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: advances one clock using the inputs currently applied.
  task automatic model_update();
    bit en, qual, re, se, he, dstore;
    int ns;
    if (rst) begin
      m_state = 0; m_hold = 0; m_steps = 0; m_cnt = 0; m_wdt = 0;
      m_addr = 0; m_data = 0;
      mp_run = 1; mp_step = 1; mp_halt = 1;
      return;
    end
    en     = (m_state == 2) || (m_state == 3);
    qual   = mem_write_m && en;
    dstore = qual && (alu_result_m == DONE_ADDR);
    re = run_req && !mp_run;
    se = step_req && !mp_step;
    he = halt_req && !mp_halt;
    ns = m_state;
    case (m_state)
      0: begin
        m_hold++;
        if (m_hold == RST_HOLD) ns = 1;
      end
      1: if (!he) begin
        if (se) begin ns = 3; m_steps = STEP_CYCLES; end
        else if (re) ns = 2;
      end
      2: begin
        if (he) ns = 1;
        else if (dstore) ns = 4;
`ifdef CORE_CTRL_WDT_EN
        else if (m_wdt >= WDT_CYCLES) ns = 5;
`endif
      end
      3: begin
        if (he) ns = 1;
        else if (dstore) ns = 4;
        else begin
          m_steps--;
          if (m_steps == 0) ns = 1;
        end
      end
      default: ns = m_state;
    endcase
`ifdef CORE_CTRL_WDT_EN
    m_wdt = (m_state == 2 && !qual) ? m_wdt + 1 : 0;
`endif
    if (qual) begin
      m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_addr = alu_result_m;
      m_data = write_data_m;
    end
    mp_run = run_req; mp_step = step_req; mp_halt = halt_req;
    m_state = ns;
  endtask

  task automatic check_all();
    chk("state",     32'(state),     32'(m_state));
    chk("core_en",   32'(core_en),   32'((m_state == 2) || (m_state == 3)));
    chk("core_rst",  32'(core_rst),  32'(m_state == 0));
    chk("done",      32'(done),      32'(m_state == 4));
    chk("store_cnt", 32'(store_cnt), 32'(m_cnt));
    chk("last_addr", last_addr, m_addr);
    chk("last_data", last_data, m_data);
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic release_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (RST_HOLD) tick();
  endtask

  task automatic pulse_run();
    run_req = 1'b1; tick(); run_req = 1'b0;
  endtask

  initial begin
    int en_cycles, cnt_before, waited;
    logic [31:0] r;
    rst = 1'b1; run_req = 0; step_req = 0; halt_req = 0;
    mem_write_m = 0; alu_result_m = 0; write_data_m = 0;

    // Reset state
    tick(); tick();
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_core_en", 32'(core_en), 32'd0);

    // Reset release: core_rst falls on the 16th edge with rst low
    rst = 1'b0;
    for (int i = 1; i <= RST_HOLD; i++) begin
      tick();
      chk("hold_core_rst", 32'(core_rst), (i < RST_HOLD) ? 32'd1 : 32'd0);
    end
    chk("hold_state", 32'(state), 32'd1);
    chk("hold_cnt", 32'(store_cnt), 32'd0);

    // Stores while halted are ignored
    mem_write_m = 1; alu_result_m = 32'h10; write_data_m = 32'd7;
    tick(); tick();
    mem_write_m = 0;
    tick();
    chk("halted_store_cnt", 32'(store_cnt), 32'd0);
    chk("halted_last_addr", last_addr, 32'd0);

    // Single step of 3 cycles, with a store in the middle
    en_cycles = 0;
    step_req = 1; tick(); step_req = 0;
    if (core_en) en_cycles++;
    mem_write_m = 1; alu_result_m = 32'h20; write_data_m = 32'hAB;
    tick(); mem_write_m = 0;
    if (core_en) en_cycles++;
    for (int i = 0; i < 4; i++) begin tick(); if (core_en) en_cycles++; end
    chk("step_en_cycles", 32'(en_cycles), 32'd3);
    chk("step_state", 32'(state), 32'd1);
    chk("step_store_cnt", 32'(store_cnt), 32'd1);
    chk("step_last_addr", last_addr, 32'h20);

    // Run to completion store
    pulse_run();
    chk("run_state", 32'(state), 32'd2);
    mem_write_m = 1; alu_result_m = 32'h30; write_data_m = 32'd5;
    tick(); tick();
    cnt_before = int'(store_cnt);
    alu_result_m = DONE_ADDR; write_data_m = 32'd25;
    tick(); mem_write_m = 0;
    chk("done_done", 32'(done), 32'd1);
    chk("done_core_en", 32'(core_en), 32'd0);
    chk("done_last_addr", last_addr, 32'h64);
    chk("done_last_data", last_data, 32'd25);
    chk("done_store_cnt", 32'(store_cnt), 32'(cnt_before + 1));
    pulse_run(); tick();
    chk("done_sticky", 32'(state), 32'd4);

    // Halt beats run when both edges coincide
    release_reset();
    pulse_run();
    halt_req = 1; run_req = 1; tick(); halt_req = 0; run_req = 0;
    chk("prio_state", 32'(state), 32'd1);
    tick();
    pulse_run();
    mem_write_m = 1; alu_result_m = 32'h40; write_data_m = 32'd9;
    tick(); tick(); mem_write_m = 0;
    rst = 1; tick(); rst = 0;
    chk("midrun_core_rst", 32'(core_rst), 32'd1);
    chk("midrun_store_cnt", 32'(store_cnt), 32'd0);

    // A button held through reset produces no edge
    run_req = 1;
    release_reset();
    repeat (3) tick();
    chk("held_btn_state", 32'(state), 32'd1);
    run_req = 0;
    tick();

`ifdef CORE_CTRL_WDT_EN
    // Watchdog: stores every 50 cycles keep it quiet
    pulse_run();
    for (int i = 1; i <= 300; i++) begin
      mem_write_m = (i % 50 == 0); alu_result_m = 32'h0; write_data_m = 32'(i);
      tick();
    end
    mem_write_m = 0;
    chk("wdt_fed_state", 32'(state), 32'd2);
    halt_req = 1; tick(); halt_req = 0; tick();
    // Without stores the timeout lands 101 cycles after entry
    pulse_run();
    waited = 0;
    while (state != 3'd5 && waited < 200) begin tick(); waited++; end
    chk("wdt_cycles", 32'(waited), 32'd101);
    chk("wdt_core_en", 32'(core_en), 32'd0);
`endif

    // Randomized traffic
    release_reset();
    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      run_req      = ($urandom_range(0, 7) == 0);
      step_req     = ($urandom_range(0, 9) == 0);
      halt_req     = ($urandom_range(0, 15) == 0);
      mem_write_m  = ($urandom_range(0, 2) == 0);
      r            = $urandom;
      alu_result_m = ($urandom_range(0, 40) == 0) ? DONE_ADDR : {r[31:2], 2'b00};
      write_data_m = $urandom;
      tick();
    end
    rst = 0; run_req = 0; step_req = 0; halt_req = 0; mem_write_m = 0;

    // Store counter saturation
    release_reset();
    pulse_run();
    mem_write_m = 1; alu_result_m = 32'h0;
    for (int i = 0; i < 65540; i++) begin
      write_data_m = 32'(i);
      tick();
    end
    mem_write_m = 0;
    chk("sat_store_cnt", 32'(store_cnt), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
